// File: rtl/vga_sync_receiver_640x480.sv
// Receive-side 640x480@60 VGA timing tracker: validates hsync/vsync geometry, locks, regenerates hcount/vcount.
// Optional measurement outputs are compiled in when VGA_RX_MEAS_EN is defined.
module vga_sync_receiver_640x480 #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_LINES  = 8,
    parameter int UNLOCK_ERRS = 3
) (
    input  logic        clk_pix,
    input  logic        rst_pix_n,
    input  logic        hsync_n_in,
    input  logic        vsync_n_in,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        active_video,
    output logic        h_locked,
    output logic        locked,
    output logic        line_err,
`ifdef VGA_RX_MEAS_EN
    output logic        frame_err,
    output logic [11:0] meas_h_total,
    output logic [7:0]  meas_h_sync,
    output logic [10:0] meas_v_total,
    output logic        meas_valid
`else
    output logic        frame_err
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ALIGN     = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  V_ALIGN     = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS       = 10'(V_VISIBLE);
    localparam logic [11:0] PER_GOOD    = 12'(H_TOTAL);
    localparam logic [11:0] PER_TIMEOUT = 12'(2 * H_TOTAL);
    localparam logic [7:0]  LOW_GOOD    = 8'(H_SYNC);
    localparam logic [10:0] LINES_GOOD  = 11'(V_TOTAL);
    localparam logic [7:0]  GOOD_LAST   = 8'(LOCK_LINES - 1);
    localparam logic [7:0]  ERR_LAST    = 8'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {SEARCH, H_LOCKED, V_ACQ, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_hist_q, vs_hist_q;
    logic [11:0] per_cnt_q, per_cnt_d;
    logic [7:0]  low_cnt_q, low_cnt_d;
    logic [7:0]  low_w_q, low_w_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;

    logic hs_fall, hs_rise, vs_fall;
    logic good_line, bad_line, timeout;

    assign hs_fall   = hs_hist_q & ~hsync_n_in;
    assign hs_rise   = ~hs_hist_q & hsync_n_in;
    assign vs_fall   = vs_hist_q & ~vsync_n_in;
    assign good_line = hs_fall && (per_cnt_q == PER_GOOD) && (low_w_q == LOW_GOOD);
    assign bad_line  = hs_fall && !good_line;
    assign timeout   = !hs_fall && (per_cnt_q >= PER_TIMEOUT);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q     <= SEARCH;
            hs_hist_q   <= 1'b1;
            vs_hist_q   <= 1'b1;
            per_cnt_q   <= '0;
            low_cnt_q   <= '0;
            low_w_q     <= '0;
            line_cnt_q  <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_hist_q   <= hsync_n_in;
            vs_hist_q   <= vsync_n_in;
            per_cnt_q   <= per_cnt_d;
            low_cnt_q   <= low_cnt_d;
            low_w_q     <= low_w_d;
            line_cnt_q  <= line_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;

        per_cnt_d = hs_fall ? 12'd1 : ((per_cnt_q == 12'hFFF) ? per_cnt_q : per_cnt_q + 12'd1);
        low_cnt_d = low_cnt_q;
        if (!hsync_n_in)
            low_cnt_d = hs_fall ? 8'd1 : ((low_cnt_q == 8'hFF) ? low_cnt_q : low_cnt_q + 8'd1);
        low_w_d = hs_rise ? low_cnt_q : low_w_q;

        // An hsync fall coincident with the vsync fall belongs to the new frame
        line_cnt_d = line_cnt_q;
        if (vs_fall)
            line_cnt_d = hs_fall ? 11'd1 : 11'd0;
        else if (hs_fall && line_cnt_q != 11'h7FF)
            line_cnt_d = line_cnt_q + 11'd1;

        case (state_q)
            SEARCH: begin
                if (good_line) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q >= GOOD_LAST)
                        state_d = H_LOCKED;
                end else if (bad_line) begin
                    good_cnt_d = '0;
                end
            end
            H_LOCKED: begin
                if (bad_line || timeout)
                    state_d = SEARCH;
                else if (vs_fall)
                    state_d = V_ACQ;
            end
            V_ACQ: begin
                if (bad_line || timeout)
                    state_d = SEARCH;
                else if (vs_fall && line_cnt_q == LINES_GOOD)
                    state_d = LOCKED;
            end
            LOCKED: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else begin
                    if (bad_line) begin
                        line_err_d = 1'b1;
                        if (err_cnt_q >= ERR_LAST)
                            state_d = SEARCH;
                        else
                            err_cnt_d = err_cnt_q + 8'd1;
                    end else if (good_line) begin
                        err_cnt_d = '0;
                    end
                    // Line check is resolved first so an unlock to SEARCH wins over a frame error
                    if (state_d == LOCKED && vs_fall && line_cnt_q != LINES_GOOD) begin
                        frame_err_d = 1'b1;
                        state_d     = V_ACQ;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        if (state_d == SEARCH) begin
            if (state_q != SEARCH)
                good_cnt_d = '0;
            line_cnt_d = '0;
        end
        if (state_d != LOCKED)
            err_cnt_d = '0;

        if (state_d == SEARCH) begin
            hcount_d = '0;
            vcount_d = '0;
        end else begin
            hcount_d = hs_fall ? H_ALIGN : ((hcount_q == H_LAST) ? 10'd0 : hcount_q + 10'd1);
            if (vs_fall)
                vcount_d = V_ALIGN;
            else if (!hs_fall && hcount_q == H_LAST)
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign h_locked     = (state_q != SEARCH);
    assign locked       = (state_q == LOCKED);
    assign active_video = locked && (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign line_err     = line_err_q;
    assign frame_err    = frame_err_q;

`ifdef VGA_RX_MEAS_EN
    logic [11:0] meas_h_total_q;
    logic [7:0]  meas_h_sync_q;
    logic [10:0] meas_v_total_q;
    logic        meas_valid_q;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            meas_h_total_q <= '0;
            meas_h_sync_q  <= '0;
            meas_v_total_q <= '0;
            meas_valid_q   <= 1'b0;
        end else begin
            if (hs_fall) begin
                meas_h_total_q <= per_cnt_q;
                meas_h_sync_q  <= low_w_q;
            end
            if (vs_fall) begin
                meas_v_total_q <= line_cnt_q;
                meas_valid_q   <= 1'b1;
            end
        end
    end

    assign meas_h_total = meas_h_total_q;
    assign meas_h_sync  = meas_h_sync_q;
    assign meas_v_total = meas_v_total_q;
    assign meas_valid   = meas_valid_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver_640x480.sv
// Bench for vga_sync_receiver_640x480 on a scaled-down geometry; a pixel-position stream model supplies expectations.
module tb_vga_sync_receiver_640x480;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int LOCKN = 8, UNLK = 3;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int HS0 = HV + HF, HS1 = HV + HF + HS;
    localparam int VS0 = VV + VF, VS1 = VV + VF + VS;

    logic       clk_pix    = 1'b0;
    logic       rst_pix_n  = 1'b1;
    logic       hsync_n_in = 1'b1;
    logic       vsync_n_in = 1'b1;
    logic [9:0] hcount, vcount;
    logic       active_video, h_locked, locked, line_err, frame_err;
`ifdef VGA_RX_MEAS_EN
    logic [11:0] meas_h_total;
    logic [7:0]  meas_h_sync;
    logic [10:0] meas_v_total;
    logic        meas_valid;
`endif

    vga_sync_receiver_640x480 #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_LINES(LOCKN), .UNLOCK_ERRS(UNLK)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
        .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in),
        .hcount(hcount), .vcount(vcount), .active_video(active_video),
        .h_locked(h_locked), .locked(locked),
        .line_err(line_err), .frame_err(frame_err)
`ifdef VGA_RX_MEAS_EN
        , .meas_h_total(meas_h_total), .meas_h_sync(meas_h_sync),
        .meas_v_total(meas_v_total), .meas_valid(meas_valid)
`endif
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0, errors = 0;
    int gy = 0, vlen = VT;
    bit prev_hs = 1'b1, prev_vs = 1'b1;
    int hs_falls, vs_falls, le_cnt, fe_cnt, hl_rise, lk_rise;
    bit hl_prev, lk_prev, chk_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One pixel of stream; after the edge the DUT counters must equal the sampled (x,y)
    task automatic pix(input logic hs, input logic vs, input int x, input int y);
        bit hf, vf;
        hf = prev_hs && !hs;
        vf = prev_vs && !vs;
        hsync_n_in = hs;
        vsync_n_in = vs;
        prev_hs = hs;
        prev_vs = vs;
        @(posedge clk_pix);
        #1;
        if (hf) hs_falls++;
        if (vf) vs_falls++;
        if (line_err) le_cnt++;
        if (frame_err) fe_cnt++;
        if (h_locked && !hl_prev && hl_rise < 0) hl_rise = hs_falls;
        if (locked && !lk_prev && lk_rise < 0) lk_rise = vs_falls;
        hl_prev = h_locked;
        lk_prev = locked;
        if (chk_en) begin
            if (hf) chk("h_align", hcount, HS0);
            if (vf) chk("v_align", vcount, VS0);
            if ($urandom_range(0, 47) == 0) begin
                chk("hcount", hcount, x);
                chk("vcount", vcount, y);
                chk("active", active_video, (x < HV && y < VV));
            end
        end
    endtask

    task automatic line(input int x0, input int len);
        for (int x = x0; x < len; x++)
            pix(!(x >= HS0 && x < HS1), !(gy >= VS0 && gy < VS1), x, gy);
        gy++;
        if (gy >= vlen) begin
            gy = 0;
            vlen = VT;
        end
    endtask

    task automatic goto_line(input int y);
        int n = 0;
        while (gy != y && n < 2 * VT) begin
            line(0, HT);
            n++;
        end
    endtask

    task automatic run_until_locked(input string tag);
        int n = 0;
        while (!locked && n < 4 * VT) begin
            line(0, HT);
            n++;
        end
        chk(tag, locked, 1);
    endtask

    task automatic clear_events();
        hs_falls = 0; vs_falls = 0; hl_rise = -1; lk_rise = -1;
        hl_prev = 1'b0; lk_prev = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hcount"}, hcount, 0);
        chk({tag, "_vcount"}, vcount, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_hlocked"}, h_locked, 0);
        chk({tag, "_line_err"}, line_err, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_active"}, active_video, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int le0, fe0, n;
        le_cnt = 0; fe_cnt = 0; chk_en = 1'b0;
        clear_events();

        // Reset state
        #2 rst_pix_n = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        chk_all_zero("rst");
`ifdef VGA_RX_MEAS_EN
        chk("rst_meas_h_total", meas_h_total, 0);
        chk("rst_meas_h_sync", meas_h_sync, 0);
        chk("rst_meas_v_total", meas_v_total, 0);
        chk("rst_meas_valid", meas_valid, 0);
`endif
        rst_pix_n = 1'b1;

        // Acquisition from a random mid-line point
        gy = $urandom_range(0, 3);
        vlen = VT;
        line($urandom_range(0, HV - 1), HT);
        run_until_locked("lock1");
        chk("hl_on_fall", hl_rise, LOCKN + 1);
        chk("lk_on_vfall", lk_rise, 2);
        chk_en = 1'b1;
        repeat (VT) line(0, HT);

        // Isolated short lines: one pulse each, lock kept
        goto_line(1 + $urandom_range(0, 4));
        le0 = le_cnt;
        chk_en = 1'b0;
        line(0, HT - 1);
        line(0, HT);
        chk("short_pulse", le_cnt - le0, 1);
        chk("short_locked", locked, 1);
        line(0, HT - 1);
        line(0, HT);
        line(0, HT - 1);
        line(0, HT);
        chk("iso_pulses", le_cnt - le0, 3);
        chk("iso_locked", locked, 1);
        line(0, HT);
        chk_en = 1'b1;
        repeat (2) line(0, HT);

        // Three consecutive long lines force SEARCH
        goto_line(1 + $urandom_range(0, 4));
        le0 = le_cnt;
        chk_en = 1'b0;
        repeat (UNLK) line(0, HT + 1);
        line(0, HT);
        chk("long_pulses", le_cnt - le0, 3);
        chk("long_locked", locked, 0);
        chk("long_hlocked", h_locked, 0);
        chk("long_hcount", hcount, 0);
        chk("long_vcount", vcount, 0);
        run_until_locked("relock_long");
        chk_en = 1'b1;
        repeat (3) line(0, HT);

        // Short frame: frame_err, one frame unlocked, then relock
        goto_line(0);
        fe0 = fe_cnt;
        vlen = VT - 1;
        chk_en = 1'b0;
        n = 0;
        while (fe_cnt == fe0 && n < 2 * VT) begin
            line(0, HT);
            n++;
        end
        chk("frame_pulse", fe_cnt - fe0, 1);
        chk("frame_unlocked", locked, 0);
        chk("frame_hlocked", h_locked, 1);
        goto_line(VS0);
        chk("frame_still_unlocked", locked, 0);
        line(0, HT);
        chk("frame_relock", locked, 1);
        chk("frame_single_pulse", fe_cnt - fe0, 1);
        chk_en = 1'b1;
        repeat (3) line(0, HT);

        // hsync stuck high: timeout to SEARCH without line_err
        goto_line(1 + $urandom_range(0, 4));
        le0 = le_cnt;
        chk_en = 1'b0;
        line(0, HT);
        repeat (2 * HT) pix(1'b1, 1'b1, 0, 0);
        chk("tmo_no_pulse", le_cnt - le0, 0);
        chk("tmo_locked", locked, 0);
        chk("tmo_hlocked", h_locked, 0);
        chk("tmo_active", active_video, 0);
        chk("tmo_hcount", hcount, 0);
        run_until_locked("relock_tmo");
        chk_en = 1'b1;
        repeat (3) line(0, HT);

        // Asynchronous reset mid-line, then reacquire
        goto_line(3);
        for (int x = 0; x <= 30; x++) pix(1'b1, 1'b1, x, gy);
        chk("pre_rst_active", active_video, 1);
        chk_en = 1'b0;
        #2 rst_pix_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk_pix);
        #1;
        clear_events();
        rst_pix_n = 1'b1;
        line(31, HT);
        run_until_locked("relock_rst");
        chk("rst_hl_on_fall", hl_rise, LOCKN + 1);
        chk("rst_lk_on_vfall", lk_rise, 2);
`ifdef VGA_RX_MEAS_EN
        chk("meas_h_total", meas_h_total, HT);
        chk("meas_h_sync", meas_h_sync, HS);
        chk("meas_v_total", meas_v_total, VT);
        chk("meas_valid", meas_valid, 1);
`endif
        chk_en = 1'b1;
        repeat (VT) line(0, HT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver_640x480.md
Name: vga_sync_receiver_640x480

Overview:
- Receive side of the 640x480@60 VGA timing interface. Consumes the active-low hsync/vsync pair on the 25 MHz pixel clock.
- Validates the line and frame geometry and locks to the stream.
- Regenerates hcount/vcount/active_video aligned to the incoming syncs, so that downstream capture and checker logic can index pixels.
- Sync inputs are already synchronous to clk_pix; no CDC inside this block.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync low width in pixels
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync low width in lines
- V_BP, 33, vertical back porch
- LOCK_LINES, 8, consecutive good lines needed to leave SEARCH
- UNLOCK_ERRS, 3, consecutive bad lines in LOCKED that force SEARCH

Ports:
- clk_pix  in  1  25 MHz pixel clock
- rst_pix_n  in  1  asynchronous reset, active-low
- hsync_n_in  in  1  incoming hsync, active low
- vsync_n_in  in  1  incoming vsync, active low
- hcount  out  10  regenerated pixel index, 0..799
- vcount  out  10  regenerated line index, 0..524
- active_video  out  1  locked && hcount<H_VISIBLE && vcount<V_VISIBLE (combinational from registers)
- h_locked  out  1  horizontal geometry validated (state H_LOCKED, V_ACQ or LOCKED)
- locked  out  1  full frame lock (state LOCKED)
- line_err  out  1  one-cycle pulse: bad line while LOCKED
- frame_err  out  1  one-cycle pulse: bad frame while LOCKED

Behaviour:
- Reset (async assert, sync release):
  - hcount=0, vcount=0, locked=0, h_locked=0, line_err=0, frame_err=0.
  - State=SEARCH; all internal counters cleared.
  - Sync history regs reset to 1 (idle high).
- Edge detect: one history flop per sync.
  - Fall = history 1 && input 0.
  - Rise = history 0 && input 1.
- Measurement counters:
  - per_cnt (12b, saturates 4095): cycles since last hsync fall. Reset to 1 on a fall.
  - low_cnt (8b, saturates 255): cycles hsync low. Latched into low_w on a rise.
  - line_cnt (11b, saturates): hsync falls since last vsync fall.
- Good line: at an hsync fall, per_cnt==H_TOTAL (800) && low_w==H_SYNC (96). Bad line: any other fall.
- Timeout: per_cnt reaches 2*H_TOTAL without an hsync fall.
- Counter alignment (states other than SEARCH):
  - hcount <= H_VISIBLE+H_FP (656) on the clock edge that samples an hsync fall. Outputs therefore lag the input by 1 cycle.
  - Otherwise hcount increments and wraps 799->0.
  - vcount increments on each hcount 799->0 wrap and wraps 524->0.
  - A vsync fall forces vcount <= V_VISIBLE+V_FP (490). It has priority over a simultaneous increment.
  - In SEARCH, hcount and vcount are held at 0.
- State machine:
  - SEARCH: a good line increments good_cnt; a bad line clears it. good_cnt==LOCK_LINES -> H_LOCKED, with hcount aligned on that same fall.
  - H_LOCKED: a vsync fall -> V_ACQ and clears line_cnt. A bad line or timeout -> SEARCH.
  - V_ACQ: on a vsync fall, line_cnt==V_TOTAL (525) -> LOCKED; otherwise stay in V_ACQ and clear line_cnt. A bad line or timeout -> SEARCH.
  - LOCKED:
    - Bad line: line_err pulse, err_cnt++. When err_cnt reaches UNLOCK_ERRS -> SEARCH.
    - Good line clears err_cnt.
    - Vsync fall with line_cnt!=525: frame_err pulse, -> V_ACQ.
    - Timeout -> SEARCH with no err pulse.
- Entering SEARCH clears hcount, vcount, good_cnt, err_cnt and line_cnt in the same cycle.
- Simultaneous hsync and vsync fall in the same cycle: both are processed. The line check is evaluated first; a SEARCH transition wins.
- Glitch handling: an hsync low shorter than H_SYNC is a bad line at the next fall.

Optional Feature:
- Macro VGA_RX_MEAS_EN.
- Defined: adds outputs meas_h_total[11:0], meas_h_sync[7:0], meas_v_total[10:0] and meas_valid.
  - meas_h_total and meas_h_sync are updated on every hsync fall, latching per_cnt and low_w.
  - meas_v_total is updated on every vsync fall, latching line_cnt.
  - meas_valid is set after the first vsync fall and cleared by reset only.
  - All four outputs reset to 0.
- Undefined: these ports and their registers do not exist; lock behaviour is identical.

Test Plan:
- Drive a standard 800x525 stream starting mid-line -> h_locked rises on the 9th hsync fall. locked rises at the second vsync fall. While locked, hcount=656 one cycle after each input hsync fall, and vcount=490 after each vsync fall.
- Locked stream, shorten one line to 799 cycles -> exactly one line_err pulse. locked stays 1, err_cnt clears on the next good line.
- Locked stream, three consecutive 801-cycle lines -> three line_err pulses, then locked=0, h_locked=0, hcount=vcount=0.
- Locked stream, frame of 524 lines -> one frame_err pulse and locked=0 for one frame. locked=1 again after the next 525-line frame.
- Locked stream, hold hsync high for 1600 cycles -> SEARCH (timeout), no line_err pulse, active_video=0.
- Assert rst_pix_n low mid-line while locked -> all outputs 0 immediately, without waiting for a clock edge. After release, relock follows the first scenario. With VGA_RX_MEAS_EN defined: meas_h_total=800, meas_h_sync=96, meas_v_total=525, meas_valid=1.
